serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller that sequences a single one-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It holds the carry between bits in a flip-flop, shifts the operands and the sum, and gives requesters a start/done handshake. It sits between a requester (register file or test FSM) and the shared full-adder cell. It trades latency for area in the lab datapath.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1–32)

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  registered final carry, held with sum

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: processes one bit per cycle.
  - DONE: pulses done.
- IDLE, start=1:
  - Load the A/B shift registers and the carry flip-flop (carry ← cin).
  - Clear the bit counter.
  - Go to SHIFT.
- SHIFT, each cycle:
  - Drive the cell with A[0], B[0] and the carry.
  - Shift the cell's sum bit into the MSB of the sum shift register.
  - Shift A and B right, and store the cell's carry-out in the carry flip-flop.
  - Increment the counter. After bit WIDTH-1, go to DONE.
- DONE:
  - Copy the sum shift register to sum and the carry to cout.
  - Assert done for one cycle.
  - With start=1, load the new operands and go directly to SHIFT (back-to-back). Otherwise go to IDLE.
- busy = 1 in SHIFT only. start in SHIFT is ignored, with no queueing.
- sum and cout change only on entry to DONE. They are stable during the next operation.
- Counter width is $clog2(WIDTH+1). WIDTH=1 spends exactly one cycle in SHIFT.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.

## Timing
- Reset (rst_n=0, asynchronous, at any time including mid-SHIFT):
  - state = IDLE, busy = 0, done = 0, sum = 0, cout = 0.
  - Shift registers, carry and counter cleared.
  - A partial operation is discarded, and done does not pulse for it.
- Latency: start is accepted at edge k. busy = 1 during cycles k+1 … k+WIDTH. done = 1 in cycle k+WIDTH+1, with sum and cout valid from that cycle.
- Throughput with back-to-back starts: one result every WIDTH+1 cycles.
- done is never high for two consecutive cycles.
- start held high continuously restarts immediately after each DONE.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds input port sub (1 bit), captured with the operands.
  - When sub=1, b is inverted bitwise at capture and the carry is loaded with 1 (cin is ignored). The result is a − b, and cout = 1 means no borrow.
  - When sub=0, behaviour is identical to the base block.
- SERIAL_ADDER_SUB_EN undefined: no sub port; add-only.

## Structure
- Shared package serial_adder_pkg holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - a constant for the counter-width function.
- One sub-module: the team's one-bit full_adder cell, instantiated once and driven by the LSBs of the shift registers and the carry flip-flop.
- All control lives in serial_adder_ctrl.

## Test plan
All scenarios use WIDTH=8.
- a=0x5A, b=0x3C, cin=0, start pulse → done exactly 9 cycles after the accept edge; sum=0x96, cout=0; busy high for 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start pulsed again mid-SHIFT with different operands → ignored; first result unchanged; exactly one done pulse.
- rst_n low at the 4th SHIFT cycle → all outputs 0 immediately; no done; a fresh start afterwards yields a correct result.
- start held high for three operations → done pulses every 9 cycles; each sum is correct and held between pulses.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=0x10, b=0x01 → sum=0x0F, cout=1.
  - sub=1, a=0x00, b=0x01 → sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter must hold 0..WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell shared by the serial adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell, one bit per clock, LSB first.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic             load, step, last;
  logic [WIDTH-1:0] areg, breg, sreg, sreg_nx;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b computed as a + ~b + 1; cout=1 then means no borrow.
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  full_adder u_fa (
    .a  (areg[0]),
    .b  (breg[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    sreg_nx            = sreg >> 1;
    sreg_nx[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result registers are written on the last SHIFT edge so they are valid
  // in the DONE cycle and stay put through the following operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg  <= '0;
      breg  <= '0;
      sreg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      areg  <= a;
      breg  <= b_in;
      carry <= c_in;
      cnt   <= '0;
    end else if (step) begin
      areg  <= areg >> 1;
      breg  <= breg >> 1;
      sreg  <= sreg_nx;
      carry <= fa_co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= sreg_nx;
        cout <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed, table-driven bench for serial_adder_ctrl (WIDTH=8); define
// SERIAL_ADDER_SUB_EN to also exercise subtract mode.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         ci = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .a     (opa),
    .b     (opb),
    .cin   (ci),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One start pulse from IDLE; checks latency, busy length, result and hold.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic vs,
                        input logic [W-1:0] es, input logic ec);
    int cyc, bcnt;
    bit got;
    @(negedge clk);
    opa = va; opb = vb; ci = vc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = vs;
`endif
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; bcnt = 0; got = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) got = 1;
    end
    check({name, ".latency"}, cyc, 9);
    check({name, ".busy"}, bcnt, 8);
    check({name, ".sum"}, sum, es);
    check({name, ".cout"}, cout, ec);
    @(negedge clk);
    check({name, ".done_1cyc"}, done, 1'b0);
    check({name, ".sum_held"}, {cout, sum}, {ec, es});
  endtask

  initial begin
    int cyc, ndone;
    bit got, held;
    logic [W:0] prev;
    logic [W-1:0] bb_a[3];
    logic [W-1:0] bb_b[3];
    logic [W:0]   bb_e[3];

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

    // reset state
    #12;
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.sum", sum, 8'h00);
    check("reset.cout", cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, vecs[i].es, vecs[i].ec);

    // start re-pulsed mid-SHIFT must be ignored
    @(negedge clk);
    opa = 8'h21; opb = 8'h43; ci = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; ndone = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 3) begin opa = 8'hF0; opb = 8'h0F; ci = 1'b1; start = 1'b1; end
      if (k == 4) start = 1'b0;
      if (done) begin
        ndone++;
        if (cyc == 0) cyc = k;
      end
    end
    check("ignore.latency", cyc, 9);
    check("ignore.ndone", ndone, 1);
    check("ignore.result", {cout, sum}, 9'h064);

    // asynchronous reset during the 4th SHIFT cycle
    @(negedge clk);
    opa = 8'hC3; opb = 8'h5A; ci = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    check("rst.busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.sum", sum, 8'h00);
    check("rst.cout", cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst.no_done", ndone, 0);
    run_op("rst.fresh", 8'hC3, 8'h5A, 1'b1, 1'b0, 8'h1E, 1'b1);

    // start held high: three back-to-back operations
    bb_a = '{8'h01, 8'h7F, 8'hFE};
    bb_b = '{8'h02, 8'h81, 8'h03};
    bb_e = '{9'h003, 9'h100, 9'h101};
    @(negedge clk);
    opa = bb_a[0]; opb = bb_b[0]; ci = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 opa = bb_a[1]; opb = bb_b[1];
    prev = '0;
    for (int i = 0; i < 3; i++) begin
      cyc = 0; got = 0; held = 1;
      while (!got && cyc < 20) begin
        @(negedge clk);
        cyc++;
        if (done) got = 1;
        else if (i > 0 && {cout, sum} !== prev) held = 0;
      end
      check($sformatf("b2b%0d.interval", i), cyc, 9);
      check($sformatf("b2b%0d.result", i), {cout, sum}, bb_e[i]);
      if (i > 0) check($sformatf("b2b%0d.held", i), held, 1'b1);
      prev = {cout, sum};
      if (i < 2) begin
        @(posedge clk);
        #1;
        if (i == 0) begin opa = bb_a[2]; opb = bb_b[2]; end
        else start = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b.done_1cyc", done, 1'b0);
    check("b2b.final_held", {cout, sum}, 9'h101);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub0", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("sub1", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_op("sub_off", 8'h10, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
